// File: rtl/toggle_hs_rx_pkg.sv
// rtl/toggle_hs_rx_pkg.sv - shared types and defaults for the toggle handshake receiver
//
// Purpose: receiver state encoding and default parameter values.
// Contents: rx_state_t (ST_INIT, ST_IDLE, ST_HOLD), DEFAULT_DATA_W,
//           DEFAULT_SYNC_STAGES, DEFAULT_CNT_W.
package toggle_hs_rx_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_HOLD = 2'd2
  } rx_state_t;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_CNT_W       = 8;

endpackage

// File: rtl/toggle_hs_rx_sync_nff.sv
// rtl/toggle_hs_rx_sync_nff.sv - N-stage single-bit synchroniser with synchronous reset
//
// Purpose: brings an asynchronous level into the clk domain; reusable on the
//          transmit side for ack_tgl.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous, active-high; clears every stage
//   d     in   asynchronous input level
//   q     out  synchronised level, STAGES cycles behind d
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - receiving end of the two-phase toggle handshake
//
// Purpose: synchronises req_tgl, turns each level change into one word on a
//          valid/ready output, and flips ack_tgl once the word is consumed.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   req_tgl   in   request toggle; each level change announces one word
//   req_data  in   sender data, stable until the matching ack_tgl change
//   ack_tgl   out  acknowledge toggle, flips once per consumed word
//   out_valid out  out_data holds an unconsumed word
//   out_data  out  captured word
//   out_ready in   downstream accepts when out_valid && out_ready
//   xfer_cnt  out  completed transfers, wraps modulo 2^CNT_W
//   proto_err out  sticky: sender toggled again before being acknowledged
module toggle_hs_rx
  import toggle_hs_rx_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              proto_err
);

  rx_state_t  state;
  logic [2:0] init_cnt;   // SYNC_STAGES is at most 4, so 3 bits suffice
  logic       req_s;
  logic       req_prev;

  sync_nff #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .reset(reset),
    .d    (req_tgl),
    .q    (req_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_cnt  <= 3'd0;
      req_prev  <= 1'b0;
      ack_tgl   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        // Let the synchroniser fill and adopt the sender's current level as
        // the baseline, so a req_tgl already high at reset release is not
        // mistaken for a request.
        ST_INIT: begin
          req_prev <= req_s;
          if (init_cnt == 3'(SYNC_STAGES)) begin
            state <= ST_IDLE;
          end else begin
            init_cnt <= init_cnt + 3'd1;
          end
        end

        ST_IDLE: begin
          if (req_s != req_prev) begin
            out_data  <= req_data;
            req_prev  <= req_s;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          // req_prev is frozen here, so an early toggle stays pending and is
          // picked up in IDLE; a second early toggle cancels it.
          if (req_s != req_prev) begin
            proto_err <= 1'b1;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            ack_tgl   <= ~ack_tgl;
            xfer_cnt  <= xfer_cnt + 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb/tb_toggle_hs_rx.sv - directed self-checking bench for toggle_hs_rx
module tb_toggle_hs_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_tgl;
  logic [7:0] req_data;
  logic       out_ready;

  logic       ack_tgl;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] xfer_cnt;
  logic       proto_err;

  logic       ack_tgl4;
  logic       out_valid4;
  logic [7:0] out_data4;
  logic [3:0] xfer_cnt4;
  logic       proto_err4;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  toggle_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_tgl(req_tgl), .req_data(req_data),
    .ack_tgl(ack_tgl), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt), .proto_err(proto_err)
  );

  toggle_hs_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .req_tgl(req_tgl), .req_data(req_data),
    .ack_tgl(ack_tgl4), .out_valid(out_valid4), .out_data(out_data4),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt4), .proto_err(proto_err4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sender model: present data, flip req_tgl, wait (bounded) for ack_tgl to flip.
  task automatic send_word(input logic [7:0] d);
    logic prev_ack;
    int   seen;
    bit   done;
    prev_ack = ack_tgl;
    seen     = 0;
    done     = 1'b0;
    req_data = d;
    req_tgl  = ~req_tgl;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (out_valid) seen++;
      if (ack_tgl != prev_ack) done = 1'b1;
    end
    chk("ack_flip", 32'(done), 32'd1);
    chk("word_data", 32'(out_data), 32'(d));
    chk("word_valid_once", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    // Reset release with req_tgl already high: no spurious word.
    reset = 1'b1; req_tgl = 1'b1; req_data = 8'h00; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("init_no_valid", 32'(out_valid), 32'd0);
    end
    chk("init_ack", 32'(ack_tgl), 32'd0);
    chk("init_xfer", 32'(xfer_cnt), 32'd0);
    chk("init_perr", 32'(proto_err), 32'd0);
    chk("init_data", 32'(out_data), 32'd0);

    // Fresh start with sender at 0.
    reset = 1'b1; req_tgl = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (4) tick();

    // Single transfer, latency = SYNC_STAGES edges then capture.
    req_data = 8'hA5; out_ready = 1'b1; req_tgl = 1'b1;
    tick(); tick();
    chk("single_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_ack_before", 32'(ack_tgl), 32'd0);
    tick();
    chk("single_valid_drop", 32'(out_valid), 32'd0);
    chk("single_ack", 32'(ack_tgl), 32'd1);
    chk("single_xfer", 32'(xfer_cnt), 32'd1);

    // Backpressure for 10 cycles.
    out_ready = 1'b0; req_data = 8'h3C; req_tgl = 1'b0;
    repeat (3) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_data", 32'(out_data), 32'h3C);
      chk("bp_hold_ack", 32'(ack_tgl), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ack", 32'(ack_tgl), 32'd0);
    chk("bp_xfer", 32'(xfer_cnt), 32'd2);

    // Back-to-back 0x01..0x10.
    for (int w = 1; w <= 16; w++) send_word(8'(w));
    chk("b2b_ack", 32'(ack_tgl), 32'd0);
    chk("b2b_xfer", 32'(xfer_cnt), 32'd18);
    chk("b2b_xfer4", 32'(xfer_cnt4), 32'd2);
    chk("b2b_perr", 32'(proto_err), 32'd0);

    // Protocol violation: two extra toggles while held.
    out_ready = 1'b0; req_data = 8'h77; req_tgl = ~req_tgl;
    repeat (3) tick();
    chk("pv_valid", 32'(out_valid), 32'd1);
    chk("pv_perr_clean", 32'(proto_err), 32'd0);
    req_tgl = ~req_tgl;
    repeat (3) tick();
    chk("pv_perr_set", 32'(proto_err), 32'd1);
    req_tgl = ~req_tgl;
    repeat (3) tick();
    chk("pv_hold_valid", 32'(out_valid), 32'd1);
    chk("pv_hold_data", 32'(out_data), 32'h77);
    chk("pv_hold_ack", 32'(ack_tgl), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("pv_accept_valid", 32'(out_valid), 32'd0);
    chk("pv_accept_ack", 32'(ack_tgl), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("pv_no_extra", 32'(out_valid), 32'd0);
      chk("pv_sticky", 32'(proto_err), 32'd1);
    end
    chk("pv_xfer", 32'(xfer_cnt), 32'd19);

    // Reset while holding a word.
    out_ready = 1'b0; req_data = 8'h5A; req_tgl = ~req_tgl;
    repeat (3) tick();
    chk("mr_valid", 32'(out_valid), 32'd1);
    reset = 1'b1; req_tgl = 1'b0;
    tick();
    chk("mr_valid_clr", 32'(out_valid), 32'd0);
    chk("mr_ack_clr", 32'(ack_tgl), 32'd0);
    chk("mr_perr_clr", 32'(proto_err), 32'd0);
    chk("mr_xfer_clr", 32'(xfer_cnt), 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    send_word(8'hC3);
    chk("mr_new_xfer", 32'(xfer_cnt), 32'd1);

    // 16 more words: 17 in total since reset, CNT_W=4 instance wraps to 1.
    for (int w = 0; w < 16; w++) send_word(8'(8'hE0 + w));
    chk("wrap_xfer8", 32'(xfer_cnt), 32'd17);
    chk("wrap_xfer4", 32'(xfer_cnt4), 32'd1);
    chk("wrap_ack", 32'(ack_tgl), 32'd1);
    chk("wrap_perr", 32'(proto_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
